bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one binary bit per clock, which keeps area to DIGITS add-3 cells plus a shift register. A start/done handshake connects it to the reaction-time counter. The BCD result drives the seven-segment display mux.

Parameters:
BIN_W, 14, width of the binary input in bits (14 covers 0..16383).
DIGITS, 4, number of BCD digits produced. Output range is 0..10^DIGITS-1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  conversion request; sampled only in IDLE
bin_in  in  BIN_W  binary value; latched on the accepted start edge
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when bcd_out/overflow update
bcd_out  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
overflow  out  1  bin_in >= 10^DIGITS for the last conversion
blank  out  DIGITS  leading-zero blank flags (present only with LEADING_ZERO_BLANK_EN)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - busy=0, done=0, overflow=0, bcd_out=0, blank=0.
  - Internal shift, scratch and counter registers are cleared.
- Two states: IDLE and SHIFT.
- IDLE:
  - On start=1 at edge k: latch bin_in into the shift register, clear the BCD scratch and the overflow flag, load bit counter = BIN_W, go to SHIFT.
  - busy=1 from edge k.
- SHIFT, each cycle:
  - Every scratch digit >= 5 gets +3 (4-bit, no carry between digits).
  - Then {scratch, shift reg} shifts left 1; the binary MSB enters the digit 0 LSB.
  - The bit shifted out of the top digit MSB is ORed into the sticky overflow flag.
  - Counter decrements by 1.
- Completion, when the counter reaches 0 after the last shift (edge k+BIN_W):
  - Register bcd_out = scratch, or all digits = 9 if overflow is set (saturation).
  - Register overflow.
  - done=1 for exactly that cycle; busy=0 in the same cycle; state returns to IDLE.
- Latency: start accepted at edge k, result and done at edge k+BIN_W. Throughput is one conversion per BIN_W cycles.
- start while busy=1 is ignored. No queueing, no error flag.
- start=1 in the done cycle is accepted (state is already IDLE), which allows back-to-back conversions with zero idle cycles.
- bin_in changes after acceptance have no effect on the running conversion.
- bcd_out and overflow hold their values between done pulses.
- Reset mid-conversion aborts immediately: no done pulse, and outputs return to reset values.
- BIN_W < 4 is legal.
- DIGITS must satisfy 10^DIGITS-1 representable; no other constraint.
- Overflow detection is exact for any BIN_W/DIGITS combination.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Port blank[DIGITS-1:0] exists and is registered on the done edge together with bcd_out.
  - blank[i]=1 when digit i and every higher digit are zero, for i>=1.
  - blank[0] is always 0, so the units digit always shows.
  - blank is all 0 when overflow=1.
  - blank resets to 0.
- Undefined: the blank port and its logic are absent; all other behaviour is identical.

Test Plan:
1. BIN_W=14, DIGITS=4. Reset, then start with bin_in=0 -> done pulses exactly 14 cycles after the start edge; bcd_out=16'h0000, overflow=0, busy high for 14 cycles.
2. bin_in=1234, then bin_in=9999 back-to-back, with the second start asserted in the first done cycle -> bcd_out=16'h1234, then 16'h9999 14 cycles later; overflow=0 both times; busy low only in the done cycles.
3. bin_in=10000 and bin_in=16383 -> bcd_out=16'h9999 and overflow=1 for each.
4. Start with bin_in=5678; pulse start with bin_in=42 at cycle 5 and change bin_in mid-run -> single done, bcd_out=16'h5678, second start ignored.
5. Start with bin_in=777; drive rst_n low at cycle 7 (async, between edges) -> outputs are 0 immediately and no done follows. Next start with 777 gives 16'h0777.
6. With LEADING_ZERO_BLANK_EN: bin_in=40 -> bcd_out=16'h0040, blank=4'b1100. bin_in=0 -> blank=4'b1110. bin_in=12000 -> blank=4'b0000, overflow=1.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One binary bit is consumed per clock, so a conversion takes BIN_W cycles.
// The result saturates to all nines when the input does not fit in DIGITS digits.
//
// Parameters:
//   BIN_W   width of the binary input
//   DIGITS  number of BCD digits produced
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only while idle
//   bin_in    binary value, latched when start is accepted
//   busy      high while a conversion is running
//   done      one-cycle pulse when bcd_out/overflow update
//   bcd_out   packed BCD result, digit 0 (units) in bits [3:0]
//   overflow  last converted value was >= 10^DIGITS
//   blank     leading-zero blank flags (only with LEADING_ZERO_BLANK_EN)
//
// Optional build macro: LEADING_ZERO_BLANK_EN adds the blank port and its logic.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [BIN_W-1:0]      shreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_sticky;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   scratch_sh;
  logic [BIN_W-1:0]      shreg_sh;
  logic                  msb_out;
  logic                  ovf_nxt;
  logic                  load;
  logic                  finish;

  // Add 3 to every digit >= 5; digits are independent, no carry between them.
  function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] s);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturated result: every digit forced to 9.
  function automatic logic [4*DIGITS-1:0] sat_nines();
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = 4'd9;
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // blank[i] set when digit i and all higher digits are zero; units never blanked.
  function automatic logic [DIGITS-1:0] lz_blank(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] b;
    logic              allz;
    b    = '0;
    allz = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz = allz & (d[4*i +: 4] == 4'd0);
      b[i] = allz;
    end
    return b;
  endfunction
`endif

  // One double-dabble step: adjust, then shift {scratch, shreg} left by one.
  // The bit leaving the top digit means the running value reached 10^DIGITS.
  always_comb begin
    adj                   = add3_digits(scratch);
    {msb_out, scratch_sh} = {adj, shreg[BIN_W-1]};
    shreg_sh              = shreg << 1;
    ovf_nxt               = ovf_sticky | msb_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        // Counter at 1 means this edge performs the final shift.
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank      <= '0;
`endif
    end else begin
      done <= finish;
      if (load) begin
        shreg      <= bin_in;
        scratch    <= '0;
        ovf_sticky <= 1'b0;
        cnt        <= CNT_W'(BIN_W);
      end else if (state == SHIFT) begin
        shreg      <= shreg_sh;
        scratch    <= scratch_sh;
        ovf_sticky <= ovf_nxt;
        cnt        <= cnt - CNT_W'(1);
      end
      if (finish) begin
        bcd_out  <= ovf_nxt ? sat_nines() : scratch_sh;
        overflow <= ovf_nxt;
`ifdef LEADING_ZERO_BLANK_EN
        blank    <= ovf_nxt ? '0 : lz_blank(scratch_sh);
`endif
      end
    end
  end

endmodule
